// File: rtl/frame_burst_mover.sv
// Packs FIFO pixels into SDRAM write bursts across ping-pong frame banks and
// streams completed frames back out burst by burst, all on one clock.
module frame_burst_mover #(
    parameter int PixelBitWidth = 16,
    parameter int BurstLength   = 8,
    parameter int FrameWidth    = 640,
    parameter int FrameHeight   = 480,
    parameter int NumFrames     = 2,
    parameter int AddressWidth  = 24
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [PixelBitWidth-1:0] i_fifo_dout,
    input  logic                     i_fifo_empty,
    output logic                     o_fifo_rd_en,
    output logic                     o_sdram_enable,
    output logic                     o_sdram_rw,
    output logic [AddressWidth-1:0]  o_sdram_addr,
    output logic [PixelBitWidth-1:0] o_sdram_wdata,
    input  logic                     i_sdram_busy,
    input  logic [PixelBitWidth-1:0] i_sdram_rdata,
    input  logic                     i_sdram_valid,
    input  logic                     i_readback_en,
    output logic [PixelBitWidth-1:0] o_pix,
    output logic                     o_pix_valid,
    output logic                     o_frame_done,
    output logic                     o_stall
);
    localparam int FRAME_WORDS      = FrameWidth * FrameHeight;
    localparam int BURSTS_PER_FRAME = FRAME_WORDS / BurstLength;
    localparam int WORD_W           = $clog2(BurstLength);
    localparam int COUNT_W          = $clog2(BurstLength + 1);
    localparam int BURST_W          = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
    localparam int BANK_W           = $clog2(NumFrames);

    localparam logic [AddressWidth-1:0] FRAME_WORDS_A = AddressWidth'(FRAME_WORDS);
    localparam logic [COUNT_W-1:0]      COUNT_FULL    = COUNT_W'(BurstLength);
    localparam logic [WORD_W-1:0]       LAST_WORD     = WORD_W'(BurstLength - 1);
    localparam logic [BURST_W-1:0]      LAST_BURST    = BURST_W'(BURSTS_PER_FRAME - 1);
    localparam logic [BANK_W-1:0]       LAST_BANK     = BANK_W'(NumFrames - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA} state_t;

    state_t                    state_reg;
    logic [PixelBitWidth-1:0]  buf_mem [BurstLength];
    logic [COUNT_W-1:0]        count_reg;
    logic                      pop_inflight_reg;
    logic [WORD_W-1:0]         word_idx_reg;
    logic [BANK_W-1:0]         wr_bank_reg;
    logic [BURST_W-1:0]        wr_burst_reg;
    logic                      rd_pending_reg;
    logic [BANK_W-1:0]         pend_bank_reg;
    logic                      rd_active_reg;
    logic [BANK_W-1:0]         rd_bank_reg;
    logic [BURST_W-1:0]        rd_burst_reg;
    logic                      sdram_enable_reg;
    logic                      sdram_rw_reg;
    logic [AddressWidth-1:0]   sdram_addr_reg;
    logic [PixelBitWidth-1:0]  sdram_wdata_reg;
    logic [PixelBitWidth-1:0]  pix_reg;
    logic                      pix_valid_reg;
    logic                      frame_done_reg;
    logic                      stall_reg;

    logic                      buf_full;
    logic                      go_read;
    logic                      fifo_pop;
    logic [BANK_W-1:0]         next_wr_bank;
    logic [AddressWidth-1:0]   wr_addr;
    logic [AddressWidth-1:0]   rd_addr;

    function automatic logic [AddressWidth-1:0] burst_addr(input logic [BANK_W-1:0] bank,
                                                         input logic [BURST_W-1:0] idx);
        return AddressWidth'(bank) * FRAME_WORDS_A + (AddressWidth'(idx) << WORD_W);
    endfunction

    assign buf_full     = (count_reg == COUNT_FULL);
    assign go_read      = !buf_full && (rd_pending_reg || rd_active_reg) && i_readback_en
                          && !pop_inflight_reg;
    // Pops are withheld in a cycle that leaves IDLE for a read, so no FIFO word
    // can land while the buffer is idle-parked behind a read burst.
    assign fifo_pop     = RST && (state_reg == IDLE) && !i_fifo_empty && !stall_reg && !go_read
                          && (({1'b0, count_reg} + {{COUNT_W{1'b0}}, pop_inflight_reg})
                              < {1'b0, COUNT_FULL});
    assign next_wr_bank = (wr_bank_reg == LAST_BANK) ? '0 : wr_bank_reg + 1'b1;
    assign wr_addr      = burst_addr(wr_bank_reg, wr_burst_reg);
    assign rd_addr      = burst_addr(rd_active_reg ? rd_bank_reg : pend_bank_reg, rd_burst_reg);

    always_ff @(posedge CLK) begin
        if (pop_inflight_reg) begin
            buf_mem[count_reg[WORD_W-1:0]] <= i_fifo_dout;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg        <= IDLE;
            count_reg        <= '0;
            pop_inflight_reg <= 1'b0;
            word_idx_reg     <= '0;
            wr_bank_reg      <= '0;
            wr_burst_reg     <= '0;
            rd_pending_reg   <= 1'b0;
            pend_bank_reg    <= '0;
            rd_active_reg    <= 1'b0;
            rd_bank_reg      <= '0;
            rd_burst_reg     <= '0;
            sdram_enable_reg <= 1'b0;
            sdram_rw_reg     <= 1'b0;
            sdram_addr_reg   <= '0;
            sdram_wdata_reg  <= '0;
            pix_reg          <= '0;
            pix_valid_reg    <= 1'b0;
            frame_done_reg   <= 1'b0;
            stall_reg        <= 1'b0;
        end else begin
            frame_done_reg   <= 1'b0;
            pix_valid_reg    <= 1'b0;
            pop_inflight_reg <= fifo_pop;
            if (pop_inflight_reg) begin
                count_reg <= count_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (buf_full) begin
                        state_reg        <= WR_REQ;
                        sdram_enable_reg <= 1'b1;
                        sdram_rw_reg     <= 1'b0;
                        sdram_addr_reg   <= wr_addr;
                        sdram_wdata_reg  <= buf_mem[0];
                    end else if (go_read) begin
                        state_reg        <= RD_REQ;
                        sdram_enable_reg <= 1'b1;
                        sdram_rw_reg     <= 1'b1;
                        sdram_addr_reg   <= rd_addr;
                        // A new read frame claims the pending bank; a later
                        // completed frame can then queue up behind it.
                        if (!rd_active_reg) begin
                            rd_active_reg  <= 1'b1;
                            rd_bank_reg    <= pend_bank_reg;
                            rd_pending_reg <= 1'b0;
                        end
                    end
                end
                WR_REQ: begin
                    if (!i_sdram_busy) begin
                        sdram_enable_reg <= 1'b0;
                        sdram_wdata_reg  <= buf_mem[1];
                        word_idx_reg     <= WORD_W'(1);
                        state_reg        <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (word_idx_reg == LAST_WORD) begin
                        state_reg       <= IDLE;
                        word_idx_reg    <= '0;
                        count_reg       <= '0;
                        sdram_wdata_reg <= '0;
                        if (wr_burst_reg == LAST_BURST) begin
                            wr_burst_reg   <= '0;
                            frame_done_reg <= 1'b1;
                            rd_pending_reg <= 1'b1;
                            pend_bank_reg  <= wr_bank_reg;
                            wr_bank_reg    <= next_wr_bank;
                            if (rd_active_reg && (rd_bank_reg == next_wr_bank)) begin
                                stall_reg <= 1'b1;
                            end
                        end else begin
                            wr_burst_reg <= wr_burst_reg + 1'b1;
                        end
                    end else begin
                        word_idx_reg    <= word_idx_reg + 1'b1;
                        sdram_wdata_reg <= buf_mem[word_idx_reg + 1'b1];
                    end
                end
                RD_REQ: begin
                    if (!i_sdram_busy) begin
                        sdram_enable_reg <= 1'b0;
                        word_idx_reg     <= '0;
                        state_reg        <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (i_sdram_valid) begin
                        pix_reg       <= i_sdram_rdata;
                        pix_valid_reg <= 1'b1;
                        if (word_idx_reg == LAST_WORD) begin
                            word_idx_reg <= '0;
                            state_reg    <= IDLE;
                            if (rd_burst_reg == LAST_BURST) begin
                                rd_burst_reg  <= '0;
                                rd_active_reg <= 1'b0;
                                stall_reg     <= 1'b0;
                            end else begin
                                rd_burst_reg <= rd_burst_reg + 1'b1;
                            end
                        end else begin
                            word_idx_reg <= word_idx_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_fifo_rd_en   = fifo_pop;
    assign o_sdram_enable = sdram_enable_reg;
    assign o_sdram_rw     = sdram_rw_reg;
    assign o_sdram_addr   = sdram_addr_reg;
    assign o_sdram_wdata  = sdram_wdata_reg;
    assign o_pix          = pix_reg;
    assign o_pix_valid    = pix_valid_reg;
    assign o_frame_done   = frame_done_reg;
    assign o_stall        = stall_reg;
endmodule

// File: tb/tb_frame_burst_mover.sv
// Directed bench for frame_burst_mover: FIFO and SDRAM models around the DUT,
// small geometry (4x2 frame, 4-word bursts, 2 banks, 8-bit addresses).
module tb_frame_burst_mover;
    localparam int PW = 16;
    localparam int BL = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] i_fifo_dout = '0;
    logic          i_fifo_empty = 1'b1;
    logic          o_fifo_rd_en;
    logic          o_sdram_enable;
    logic          o_sdram_rw;
    logic [AW-1:0] o_sdram_addr;
    logic [PW-1:0] o_sdram_wdata;
    logic          i_sdram_busy = 1'b0;
    logic [PW-1:0] i_sdram_rdata = '0;
    logic          i_sdram_valid = 1'b0;
    logic          i_readback_en = 1'b0;
    logic [PW-1:0] o_pix;
    logic          o_pix_valid;
    logic          o_frame_done;
    logic          o_stall;

    always #5 clk = ~clk;

    frame_burst_mover #(
        .PixelBitWidth(PW), .BurstLength(BL), .FrameWidth(4), .FrameHeight(2),
        .NumFrames(2), .AddressWidth(AW)
    ) dut (
        .CLK(clk), .RST(rst_n),
        .i_fifo_dout(i_fifo_dout), .i_fifo_empty(i_fifo_empty), .o_fifo_rd_en(o_fifo_rd_en),
        .o_sdram_enable(o_sdram_enable), .o_sdram_rw(o_sdram_rw), .o_sdram_addr(o_sdram_addr),
        .o_sdram_wdata(o_sdram_wdata), .i_sdram_busy(i_sdram_busy),
        .i_sdram_rdata(i_sdram_rdata), .i_sdram_valid(i_sdram_valid),
        .i_readback_en(i_readback_en), .o_pix(o_pix), .o_pix_valid(o_pix_valid),
        .o_frame_done(o_frame_done), .o_stall(o_stall)
    );

    int            checks = 0;
    int            failures = 0;
    logic [PW-1:0] fifo_q[$];
    logic          fifo_pop_q = 1'b0;
    logic          toggle_en = 1'b0;
    logic          empty_gate = 1'b0;
    int            pop_cnt = 0;
    int            underflow_cnt = 0;
    logic [8:0]    req_log[$];
    logic [PW-1:0] wr_log[$];
    logic [PW-1:0] pix_log[$];
    int            done_cnt = 0;
    int            wr_left = 0;
    int            rd_left = 0;
    logic [PW-1:0] rd_next = 16'h00A1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: data appears one cycle after the pop.
    always @(posedge clk) fifo_pop_q <= o_fifo_rd_en;
    always @(negedge clk) begin
        if (fifo_pop_q === 1'b1) begin
            if (fifo_q.size() > 0) begin
                i_fifo_dout = fifo_q.pop_front();
                pop_cnt++;
            end else begin
                underflow_cnt++;
            end
        end
        empty_gate   = toggle_en ? ~empty_gate : 1'b0;
        i_fifo_empty = (fifo_q.size() == 0) || empty_gate;
    end

    // SDRAM model and output monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_left       = 0;
            rd_left       = 0;
            i_sdram_valid = 1'b0;
        end else begin
            if (o_pix_valid || i_sdram_valid)
                check("pix_lat", {o_pix_valid, o_pix}, {i_sdram_valid, i_sdram_rdata});
            if (o_pix_valid) pix_log.push_back(o_pix);
            if (o_frame_done) done_cnt++;
            if (o_sdram_enable && !i_sdram_busy && !o_sdram_rw) wr_left = BL;
            if (wr_left > 0) begin
                wr_log.push_back(o_sdram_wdata);
                wr_left--;
            end
            if (rd_left > 0) begin
                i_sdram_valid = 1'b1;
                i_sdram_rdata = rd_next;
                rd_next++;
                rd_left--;
            end else begin
                i_sdram_valid = 1'b0;
            end
            if (o_sdram_enable && !i_sdram_busy) begin
                req_log.push_back({o_sdram_rw, o_sdram_addr});
                $display("req rw=%0d addr=%0d", o_sdram_rw, o_sdram_addr);
                if (o_sdram_rw) rd_left = BL;
            end
        end
    end

    function automatic logic [63:0] outs_now();
        return 64'({o_fifo_rd_en, o_sdram_enable, o_sdram_rw, o_sdram_addr, o_sdram_wdata,
                    o_pix, o_pix_valid, o_frame_done, o_stall});
    endfunction
    function automatic logic [8:0] req_at(input int i);
        return (req_log.size() > i) ? req_log[i] : 9'h1FF;
    endfunction
    function automatic logic [PW-1:0] wr_at(input int i);
        return (wr_log.size() > i) ? wr_log[i] : 16'hFFFF;
    endfunction
    function automatic logic [PW-1:0] pix_at(input int i);
        return (pix_log.size() > i) ? pix_log[i] : 16'hFFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        i_readback_en = 1'b0;
        i_sdram_busy  = 1'b0;
        toggle_en     = 1'b0;
        fifo_q.delete();
        repeat (3) tick();
        check("rst_outs", outs_now(), 64'd0);
        req_log.delete();
        wr_log.delete();
        pix_log.delete();
        done_cnt = 0;
        pop_cnt  = 0;
        rd_next  = 16'h00A1;
        rst_n    = 1'b1;
    endtask

    task automatic push_range(input int first, input int last);
        for (int v = first; v <= last; v++) fifo_q.push_back(PW'(v));
    endtask

    // which: 0 = write words, 1 = requests, 2 = output pixels
    task automatic wait_for(input int which, input int n, input int budget, input string tag);
        int sz;
        sz = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            sz = (which == 0) ? wr_log.size() : (which == 1) ? req_log.size() : pix_log.size();
            if (sz >= n) break;
        end
        check(tag, sz, n);
    endtask

    initial begin
        logic [8:0] exp_req [9];

        // single burst
        do_reset();
        push_range(1, 4);
        wait_for(0, 4, 60, "t1_wr_to");
        repeat (3) tick();
        check("t1_nreq", req_log.size(), 1);
        check("t1_addr", req_at(0), 9'h000);
        for (int i = 0; i < 4; i++) check("t1_wdata", wr_at(i), i + 1);
        check("t1_pops", pop_cnt, 4);

        // frame completion, next bank, wrap
        push_range(5, 8);
        wait_for(0, 8, 60, "t2_wr_to");
        repeat (3) tick();
        check("t2_done1", done_cnt, 1);
        check("t2_addr1", req_at(1), 9'h004);
        push_range(9, 20);
        wait_for(0, 20, 300, "t2_wr20_to");
        repeat (3) tick();
        check("t2_addr2", req_at(2), 9'h008);
        check("t2_addr3", req_at(3), 9'h00C);
        check("t2_wrap", req_at(4), 9'h000);
        check("t2_done2", done_cnt, 2);
        for (int i = 4; i < 20; i++) check("t2_wdata", wr_at(i), i + 1);
        check("t2_pops", pop_cnt, 20);

        // read-back of frame 0
        do_reset();
        push_range(1, 8);
        wait_for(0, 8, 100, "t3_wr_to");
        repeat (2) tick();
        i_readback_en = 1'b1;
        wait_for(2, 8, 100, "t3_pix_to");
        repeat (3) tick();
        check("t3_nreq", req_log.size(), 4);
        check("t3_raddr0", req_at(2), 9'h100);
        check("t3_raddr1", req_at(3), 9'h104);
        for (int i = 0; i < 8; i++) check("t3_pix", pix_at(i), 16'h00A1 + i);

        // busy during write request
        do_reset();
        i_sdram_busy = 1'b1;
        push_range(1, 4);
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_sdram_enable) break;
        end
        check("t4_en_seen", o_sdram_enable, 1);
        repeat (5) begin
            tick();
            check("t4_en_hold", o_sdram_enable, 1);
            check("t4_addr_hold", {o_sdram_rw, o_sdram_addr}, 9'h000);
        end
        check("t4_no_words", wr_log.size(), 0);
        i_sdram_busy = 1'b0;
        wait_for(0, 4, 40, "t4_wr_to");
        repeat (2) tick();
        check("t4_nreq", req_log.size(), 1);
        for (int i = 0; i < 4; i++) check("t4_wdata", wr_at(i), i + 1);

        // writer stalls on the bank the reader still holds
        do_reset();
        push_range(1, 8);
        wait_for(0, 8, 100, "t5_wr_to");
        repeat (2) tick();
        i_readback_en = 1'b1;
        wait_for(1, 3, 40, "t5_rreq_to");
        i_readback_en = 1'b0;
        wait_for(2, 4, 40, "t5_pix_to");
        repeat (3) tick();
        check("t5_nostall", o_stall, 0);
        push_range(9, 20);
        wait_for(0, 16, 200, "t5_wr16_to");
        repeat (4) tick();
        check("t5_stall", o_stall, 1);
        repeat (6) begin
            tick();
            check("t5_rd_en", o_fifo_rd_en, 0);
        end
        check("t5_pops", pop_cnt, 16);
        check("t5_done", done_cnt, 2);
        i_readback_en = 1'b1;
        wait_for(0, 20, 300, "t5_wr20_to");
        repeat (3) tick();
        check("t5_unstall", o_stall, 0);
        exp_req = '{9'h000, 9'h004, 9'h100, 9'h008, 9'h00C, 9'h104, 9'h108, 9'h10C, 9'h000};
        check("t5_nreq", req_log.size(), 9);
        for (int i = 0; i < 9; i++) check("t5_req", req_at(i), exp_req[i]);
        check("t5_npix", pix_log.size(), 16);
        for (int i = 16; i < 20; i++) check("t5_wdata", wr_at(i), i + 1);

        // FIFO empty toggling every cycle
        do_reset();
        toggle_en = 1'b1;
        push_range(1, 8);
        wait_for(0, 8, 300, "t6_wr_to");
        repeat (3) tick();
        toggle_en = 1'b0;
        for (int i = 0; i < 8; i++) check("t6_wdata", wr_at(i), i + 1);
        check("t6_pops", pop_cnt, 8);
        check("t6_nreq", req_log.size(), 2);

        // reset during WR_DATA
        do_reset();
        push_range(1, 4);
        wait_for(1, 1, 60, "t7_req_to");
        rst_n = 1'b0;
        tick();
        check("t7_rst_outs", outs_now(), 64'd0);
        do_reset();
        push_range(5, 8);
        wait_for(0, 4, 60, "t7_wr_to");
        repeat (2) tick();
        check("t7_nreq", req_log.size(), 1);
        check("t7_addr", req_at(0), 9'h000);
        for (int i = 0; i < 4; i++) check("t7_wdata", wr_at(i), i + 5);

        check("underflow", underflow_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
